// File: rtl/rect_plotter.sv
// rect_plotter: fills one clipped rectangle per command, emitting one
// pixel per clock in row-major order towards the VGA adapter.
module rect_plotter #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COL_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_x,
    input  logic [6:0]       cmd_y,
    input  logic [7:0]       cmd_w,
    input  logic [6:0]       cmd_h,
    input  logic [COL_W-1:0] cmd_colour,
    input  logic             cmd_clear,
    output logic [7:0]       x,
    output logic [6:0]       y,
    output logic [COL_W-1:0] colour,
    output logic             plot,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [7:0]       r_x;
    logic [6:0]       r_y;
    logic [7:0]       r_x0;
    logic [7:0]       r_xend;
    logic [6:0]       r_yend;
    logic [COL_W-1:0] r_colour;
    logic             r_plot;
    logic             r_busy;
    logic             r_done;

    logic [8:0]       w_room_x;
    logic [8:0]       w_room_y;
    logic [8:0]       w_ew;
    logic [8:0]       w_eh;
    logic [7:0]       w_x0;
    logic [6:0]       w_y0;
    logic [7:0]       w_xend;
    logic [6:0]       w_yend;
    logic             w_zero;
    logic             w_accept;

    assign cmd_ready = (r_state == S_IDLE);
    assign w_accept  = cmd_valid && cmd_ready;

    // Clip against the screen edges with 9-bit math so nothing wraps.
    always_comb begin
        w_room_x = 9'(SCREEN_W) - {1'b0, cmd_x};
        w_room_y = 9'(SCREEN_H) - {2'b00, cmd_y};
        w_x0     = cmd_x;
        w_y0     = cmd_y;
        w_ew     = 9'd0;
        w_eh     = 9'd0;
        if (cmd_clear) begin
            w_x0 = 8'd0;
            w_y0 = 7'd0;
            w_ew = 9'(SCREEN_W);
            w_eh = 9'(SCREEN_H);
        end else begin
            if ({1'b0, cmd_x} < 9'(SCREEN_W)) begin
                if ({1'b0, cmd_w} < w_room_x) begin
                    w_ew = {1'b0, cmd_w};
                end else begin
                    w_ew = w_room_x;
                end
            end
            if ({2'b00, cmd_y} < 9'(SCREEN_H)) begin
                if ({2'b00, cmd_h} < w_room_y) begin
                    w_eh = {2'b00, cmd_h};
                end else begin
                    w_eh = w_room_y;
                end
            end
        end
    end

    assign w_zero = (w_ew == 9'd0) || (w_eh == 9'd0);
    assign w_xend = w_x0 + w_ew[7:0] - 8'd1;
    assign w_yend = w_y0 + w_eh[6:0] - 7'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_x0     <= 8'd0;
            r_xend   <= 8'd0;
            r_yend   <= 7'd0;
            r_colour <= '0;
            r_plot   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_plot <= 1'b0;
                    if (w_accept) begin
                        r_busy <= 1'b1;
                        if (w_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state  <= S_DRAW;
                            r_x      <= w_x0;
                            r_y      <= w_y0;
                            r_x0     <= w_x0;
                            r_xend   <= w_xend;
                            r_yend   <= w_yend;
                            r_colour <= cmd_colour;
                            r_plot   <= 1'b1;
                        end
                    end
                end
                S_DRAW: begin
                    if (r_x == r_xend) begin
                        if (r_y == r_yend) begin
                            r_state <= S_DONE;
                            r_plot  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_x <= r_x0;
                            r_y <= r_y + 7'd1;
                        end
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_plot  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_plot  <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
    assign plot   = r_plot;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: scoreboard bench; a rectangle model queues expected
// pixels and done pulses with their cycle, a monitor compares them.
module tb_rect_plotter;

    localparam int SW = 160;
    localparam int SH = 120;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_x;
    logic [6:0] cmd_y;
    logic [7:0] cmd_w;
    logic [6:0] cmd_h;
    logic [2:0] cmd_colour;
    logic       cmd_clear;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    rect_plotter #(.SCREEN_W(SW), .SCREEN_H(SH), .COL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_w      (cmd_w),
        .cmd_h      (cmd_h),
        .cmd_colour (cmd_colour),
        .cmd_clear  (cmd_clear),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_done;
        int px;
        int py;
        int col;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, expv, cyc);
        end
    endtask

    // Reference: clip the rectangle, then list its pixels row by row.
    task automatic model(input int cx, input int cy, input int cw,
                         input int ch, input int col, input bit clr,
                         input int c0);
        int x0, y0, ew, eh, k;
        if (clr) begin
            x0 = 0; y0 = 0; ew = SW; eh = SH;
        end else begin
            x0 = cx; y0 = cy;
            ew = (cx >= SW) ? 0 : ((cw < SW - cx) ? cw : SW - cx);
            eh = (cy >= SH) ? 0 : ((ch < SH - cy) ? ch : SH - cy);
        end
        k = 0;
        for (int yy = 0; yy < eh; yy++) begin
            for (int xx = 0; xx < ew; xx++) begin
                q.push_back('{1'b0, x0 + xx, y0 + yy, col, c0 + k});
                k++;
            end
        end
        q.push_back('{1'b1, 0, 0, 0, c0 + k});
    endtask

    task automatic issue(input int cx, input int cy, input int cw,
                         input int ch, input int col, input bit clr,
                         output int e0);
        int t;
        @(negedge clk);
        cmd_x      = 8'(cx);
        cmd_y      = 7'(cy);
        cmd_w      = 8'(cw);
        cmd_h      = 7'(ch);
        cmd_colour = 3'(col);
        cmd_clear  = clr;
        cmd_valid  = 1'b1;
        t = 0;
        while (!cmd_ready && t < 30000) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            e0 = -1;
        end else begin
            e0 = cyc + 1;
            model(cx, cy, cw, ch, col, clr, e0);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            cmd_x     = 8'($urandom);
            cmd_w     = 8'($urandom);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("busy_vs_ready", int'(busy), int'(!cmd_ready));
            if (plot && cmd_ready) chk("ready_in_draw", 1, 0);
            if (last_done >= 0 && cyc == last_done + 1)
                chk("ready_after_done", int'(cmd_ready), 1);
            if (plot || done) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", int'({plot, done}), 0);
                end else begin
                    e = q.pop_front();
                    if (plot) begin
                        chk("pix_kind", int'(e.is_done), 0);
                        chk("pix_x", int'(x), e.px);
                        chk("pix_y", int'(y), e.py);
                        chk("pix_col", int'(colour), e.col);
                        chk("pix_cyc", cyc, e.cyc);
                        chk("pix_nodone", int'(done), 0);
                    end else begin
                        chk("done_kind", int'(e.is_done), 1);
                        chk("done_cyc", cyc, e.cyc);
                        chk("done_busy", int'(busy), 1);
                        last_done = cyc;
                    end
                end
            end else if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_out", 0, 1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        int ea, eb, e0, t;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_w      = '0;
        cmd_h      = '0;
        cmd_colour = '0;
        cmd_clear  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        #2 rst = 1'b0;

        issue(10, 20, 3, 2, 6, 1'b0, e0);
        issue(158, 119, 5, 3, 3, 1'b0, e0);

        issue(5, 5, 0, 4, 1, 1'b0, e0);
        @(negedge clk);
        chk("zero_done", int'(done), 1);
        chk("zero_busy", int'(busy), 1);
        chk("zero_plot", int'(plot), 0);
        @(negedge clk);
        chk("zero_busy_end", int'(busy), 0);
        chk("zero_ready", int'(cmd_ready), 1);

        issue(200, 10, 5, 5, 2, 1'b0, e0);

        issue(77, 33, 9, 9, 0, 1'b1, e0);

        issue(5, 5, 1, 1, 4, 1'b0, ea);
        issue(7, 7, 2, 1, 5, 1'b0, eb);
        chk("b2b_accept", eb, ea + 3);

        for (int i = 0; i < 40; i++) begin
            issue($urandom_range(0, 170), $urandom_range(0, 127),
                  $urandom_range(0, 24), $urandom_range(0, 12),
                  $urandom_range(0, 7), 1'b0, e0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        issue(30, 40, 4, 4, 7, 1'b0, e0);
        t = 0;
        while (cyc < e0 + 3 && t < 100) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b1;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        q.delete();
        last_done = -1;
        @(negedge clk);
        #2 rst = 1'b0;

        issue(2, 3, 2, 2, 5, 1'b0, e0);

        t = 0;
        while (q.size() > 0 && t < 30000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
